idct_dual_ram_responder: RTL and testbench

- Synthesizable memory responder for the Bambu minimal-memory master interface driven by the generated Fast_IDCT core.
- Holds one 8x8 coefficient block of 64 x 16-bit words, shared in place by input and output.
- Serves the accelerator's two memory channels every cycle.
- Exposes a single-word host port for loading coefficients and unloading results while the accelerator is not accessing memory.

---
 rtl/idct_mem_pkg.sv | 19 +
 rtl/idct_ram_lane.sv | 60 ++++++
 rtl/idct_dual_ram_responder.sv | 87 ++++++++
 tb/tb_idct_dual_ram_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/idct_mem_pkg.sv
// idct_mem_pkg: shared constants, decode helpers and host arbiter states for the IDCT block RAM responder.
package idct_mem_pkg;
    localparam int WORD_W = 16;
    localparam int LANES = 2;
    localparam int SIZE_W = 5;

    typedef enum logic {IDLE, SERVE} host_state_t;

    // Sizes of a full word or more saturate to all ones; size 0 selects nothing.
    function automatic logic [WORD_W-1:0] size_to_mask(input logic [SIZE_W-1:0] size);
        logic [WORD_W:0] m;
        m = ({{WORD_W{1'b0}}, 1'b1} << size) - {{WORD_W{1'b0}}, 1'b1};
        return size[SIZE_W-1] ? '1 : m[WORD_W-1:0];
    endfunction

    function automatic logic [30:0] byte_to_index(input logic [31:0] addr);
        return addr[31:1];
    endfunction
endpackage

// File: rtl/idct_ram_lane.sv
// idct_ram_lane: one accelerator channel -- decodes the request, range-checks and masks it,
// and delays the completion pulse and read data by the configured latency.
module idct_ram_lane import idct_mem_pkg::*; #(
    parameter int DEPTH = 64,
    parameter int READ_LATENCY = 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              oe,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [SIZE_W-1:0] size,
    input  logic [WORD_W-1:0] rd_word,
    output logic [AW-1:0]     idx,
    output logic [WORD_W-1:0] mask,
    output logic              wr_en,
    output logic [WORD_W-1:0] wr_data,
    output logic              active,
    output logic              err_evt,
    output logic              rdy,
    output logic [WORD_W-1:0] rdata
);
    logic [30:0] full_idx;
    logic in_range;
    logic [WORD_W-1:0] rd_val;
    logic [READ_LATENCY-1:0] rdy_q;
    logic [WORD_W-1:0] dat_q [READ_LATENCY];

    always_comb begin
        full_idx = byte_to_index(addr);
        in_range = (full_idx >> AW) == '0;
        idx = full_idx[AW-1:0];
        active = oe | we;
        mask = size_to_mask(size);
        wr_en = we & ~oe & in_range;
        wr_data = wdata & mask;
        err_evt = (oe & we) | (active & ~in_range);
        rd_val = (oe & ~we & in_range) ? (rd_word & mask) : '0;
    end

    // Every accepted request, including dropped or illegal ones, completes; only reads carry data.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdy_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                rdy_q[i] <= rdy_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
            rdy_q[0] <= active;
            dat_q[0] <= rd_val;
        end
    end

    assign rdy = rdy_q[READ_LATENCY-1];
    assign rdata = dat_q[READ_LATENCY-1];
endmodule

// File: rtl/idct_dual_ram_responder.sv
// idct_dual_ram_responder: dual-channel 8x8 coefficient RAM for the Fast_IDCT core,
// with a host port that is served only in cycles where the accelerator is idle.
module idct_dual_ram_responder #(
    parameter int DEPTH = 64,
    parameter int WORD_W = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          Mout_oe_ram,
    input  logic [1:0]          Mout_we_ram,
    input  logic [63:0]         Mout_addr_ram,
    input  logic [2*WORD_W-1:0] Mout_Wdata_ram,
    input  logic [9:0]          Mout_data_ram_size,
    output logic [2*WORD_W-1:0] M_Rdata_ram,
    output logic [1:0]          M_DataRdy,
    input  logic                host_req,
    input  logic                host_we,
    input  logic [5:0]          host_addr,
    input  logic [WORD_W-1:0]   host_wdata,
    output logic [WORD_W-1:0]   host_rdata,
    output logic                host_ack,
    output logic                err
);
    import idct_mem_pkg::*;
    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0] idx [LANES];
    logic [WORD_W-1:0] mask [LANES];
    logic [WORD_W-1:0] wr_data [LANES];
    logic [WORD_W-1:0] rdata [LANES];
    logic [LANES-1:0] wr_en, active, err_evt, rdy;
    host_state_t state_q, state_d;
    logic host_fire;

    for (genvar c = 0; c < LANES; c++) begin : g_lane
        idct_ram_lane #(.DEPTH(DEPTH), .READ_LATENCY(READ_LATENCY)) u_lane (
            .clock   (clock),
            .reset   (reset),
            .oe      (Mout_oe_ram[c]),
            .we      (Mout_we_ram[c]),
            .addr    (Mout_addr_ram[32*c +: 32]),
            .wdata   (Mout_Wdata_ram[WORD_W*c +: WORD_W]),
            .size    (Mout_data_ram_size[SIZE_W*c +: SIZE_W]),
            .rd_word (mem[idx[c]]),
            .idx     (idx[c]),
            .mask    (mask[c]),
            .wr_en   (wr_en[c]),
            .wr_data (wr_data[c]),
            .active  (active[c]),
            .err_evt (err_evt[c]),
            .rdy     (rdy[c]),
            .rdata   (rdata[c])
        );
        assign M_Rdata_ram[WORD_W*c +: WORD_W] = rdata[c];
    end

    assign M_DataRdy = rdy;
    assign host_fire = state_q == IDLE && host_req && active == '0;

    // Later lanes overwrite earlier ones, so channel 1 wins a same-index write; merges use the old word.
    always_ff @(posedge clock) begin
        if (host_fire && host_we) mem[host_addr] <= host_wdata;
        for (int c = 0; c < LANES; c++)
            if (wr_en[c]) mem[idx[c]] <= wr_data[c] | (mem[idx[c]] & ~mask[c]);
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb state_d = host_fire ? SERVE : IDLE;

    always_comb host_ack = state_q == SERVE;

    always_ff @(posedge clock) begin
        if (reset) begin
            host_rdata <= '0;
            err <= 1'b0;
        end else begin
            host_rdata <= (host_fire && !host_we) ? mem[host_addr] : '0;
            err <= err | (|err_evt);
        end
    end
endmodule

// File: tb/tb_idct_dual_ram_responder.sv
// tb_idct_dual_ram_responder: directed checks of two responders (latency 1 and 2) driven by shared stimulus.
module tb_idct_dual_ram_responder;
    logic clock, reset;
    logic [1:0] oe, we;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic [9:0] size;
    logic host_req, host_we;
    logic [5:0] host_addr;
    logic [15:0] host_wdata;
    logic [31:0] rdata_a, rdata_b;
    logic [1:0] rdy_a, rdy_b;
    logic [15:0] hrd_a, hrd_b;
    logic hack_a, hack_b, err_a, err_b;
    int n_checks = 0;
    int n_fail = 0;

    idct_dual_ram_responder #(.READ_LATENCY(1)) dut_a (
        .clock(clock), .reset(reset), .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
        .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size), .M_Rdata_ram(rdata_a), .M_DataRdy(rdy_a),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(hrd_a), .host_ack(hack_a), .err(err_a)
    );

    idct_dual_ram_responder #(.READ_LATENCY(2)) dut_b (
        .clock(clock), .reset(reset), .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
        .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size), .M_Rdata_ram(rdata_b), .M_DataRdy(rdy_b),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(hrd_b), .host_ack(hack_b), .err(err_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_accel;
        oe = '0; we = '0; addr = '0; wdata = '0; size = '0;
    endtask

    task automatic set_ch(input int c, input logic o, input logic w, input logic [31:0] a,
                          input logic [15:0] d, input logic [4:0] s);
        oe[c] = o; we[c] = w; addr[32*c +: 32] = a; wdata[16*c +: 16] = d; size[5*c +: 5] = s;
    endtask

    task automatic host_write(input logic [5:0] a, input logic [15:0] d);
        host_req = 1; host_we = 1; host_addr = a; host_wdata = d;
        tick;
        check("hw_ack", {31'd0, hack_a}, 32'd1);
        host_req = 0; host_we = 0;
        tick;
    endtask

    task automatic host_read(input string tag, input logic [5:0] a, input logic [15:0] exp);
        host_req = 1; host_we = 0; host_addr = a;
        tick;
        check({tag, "_a"}, {15'd0, hack_a, hrd_a}, {15'd0, 1'b1, exp});
        check({tag, "_b"}, {15'd0, hack_b, hrd_b}, {15'd0, 1'b1, exp});
        host_req = 0;
        tick;
    endtask

    initial begin
        idle_accel;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        reset = 1;
        tick; tick;
        reset = 0;
        check("rst_rdata", rdata_a, 32'h0);
        check("rst_rdy", {30'd0, rdy_a}, 32'h0);
        check("rst_host", {15'd0, hack_a, hrd_a}, 32'h0);
        check("rst_err", {31'd0, err_a}, 32'h0);

        host_write(6'd0, 16'hFF10);
        set_ch(0, 1, 0, 32'h0, 16'h0, 5'd16);
        tick;
        check("rd0_rdy_a", {30'd0, rdy_a}, 32'h1);
        check("rd0_data_a", rdata_a, 32'h0000FF10);
        check("rd0_rdy_b_early", {30'd0, rdy_b}, 32'h0);
        idle_accel;
        tick;
        check("rd0_rdy_a_once", {30'd0, rdy_a}, 32'h0);
        check("rd0_rdy_b", {30'd0, rdy_b}, 32'h1);
        check("rd0_data_b", rdata_b, 32'h0000FF10);
        tick;
        check("rd0_rdy_b_once", {30'd0, rdy_b}, 32'h0);

        host_write(6'd63, 16'h1234);
        set_ch(1, 0, 1, 32'h7E, 16'hABCD, 5'd8);
        tick;
        check("wr63_rdy", {30'd0, rdy_a}, 32'h2);
        idle_accel;
        tick;
        host_read("mem63", 6'd63, 16'h12CD);

        set_ch(1, 0, 1, 32'h0A, 16'h1111, 5'd16);
        set_ch(0, 0, 1, 32'h0A, 16'h2222, 5'd16);
        tick;
        check("coll_rdy", {30'd0, rdy_a}, 32'h3);
        idle_accel;
        tick;
        host_read("mem5", 6'd5, 16'h1111);

        host_write(6'd3, 16'h002F);
        set_ch(0, 1, 0, 32'h6, 16'h0, 5'd16);
        set_ch(1, 0, 1, 32'h6, 16'h7777, 5'd16);
        tick;
        check("rw_old_a", rdata_a, 32'h0000002F);
        check("rw_rdy", {30'd0, rdy_a}, 32'h3);
        idle_accel;
        tick;
        check("rw_old_b", rdata_b, 32'h0000002F);
        set_ch(0, 1, 0, 32'h6, 16'h0, 5'd16);
        tick;
        check("rw_new", rdata_a, 32'h00007777);
        idle_accel;
        tick;

        check("err_clean", {31'd0, err_a}, 32'h0);
        set_ch(0, 1, 0, 32'h80, 16'h0, 5'd16);
        set_ch(1, 0, 1, 32'h80, 16'h5555, 5'd16);
        tick;
        check("oor_rdy", {30'd0, rdy_a}, 32'h3);
        check("oor_data", rdata_a, 32'h0);
        check("oor_err", {31'd0, err_a}, 32'h1);
        idle_accel;
        tick;
        host_read("oor_mem0", 6'd0, 16'hFF10);

        reset = 1;
        tick; tick;
        reset = 0;
        check("err_rst_a", {31'd0, err_a}, 32'h0);
        check("err_rst_b", {31'd0, err_b}, 32'h0);
        set_ch(0, 1, 1, 32'h0, 16'h0, 5'd16);
        tick;
        check("ill_rdy", {30'd0, rdy_a}, 32'h1);
        check("ill_data", rdata_a, 32'h0);
        check("ill_err", {31'd0, err_a}, 32'h1);
        idle_accel;
        tick;
        check("ill_err_sticky", {31'd0, err_b}, 32'h1);
        host_read("ill_mem0", 6'd0, 16'hFF10);

        set_ch(0, 0, 1, 32'h0, 16'hFFFF, 5'd0);
        tick;
        idle_accel;
        tick;
        host_read("size0_mem0", 6'd0, 16'hFF10);
        set_ch(0, 1, 0, 32'h0, 16'h0, 5'd4);
        tick;
        check("size4", rdata_a, 32'h0);
        check("size4_rdy", {30'd0, rdy_a}, 32'h1);
        set_ch(0, 1, 0, 32'h0, 16'h0, 5'd12);
        tick;
        check("size12", rdata_a, 32'h00000F10);
        set_ch(0, 1, 0, 32'h0, 16'h0, 5'd31);
        tick;
        check("size31", rdata_a, 32'h0000FF10);
        idle_accel;
        tick;

        host_req = 1; host_we = 0; host_addr = 6'd5;
        set_ch(0, 1, 0, 32'h0, 16'h0, 5'd16);
        for (int i = 0; i < 4; i++) begin
            tick;
            check("starve", {31'd0, hack_a}, 32'h0);
        end
        idle_accel;
        tick;
        check("starve_ack", {15'd0, hack_a, hrd_a}, {15'd0, 1'b1, 16'h1111});
        host_req = 0;
        tick;
        check("starve_ack_once", {31'd0, hack_a}, 32'h0);

        set_ch(0, 1, 0, 32'h0, 16'h0, 5'd16);
        tick;
        reset = 1;
        idle_accel;
        tick;
        reset = 0;
        check("flush_b0", {30'd0, rdy_b}, 32'h0);
        tick;
        check("flush_b1", {30'd0, rdy_b}, 32'h0);
        check("flush_a", {30'd0, rdy_a}, 32'h0);
        host_read("retain_mem0", 6'd0, 16'hFF10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
